cam_frame_loader: RTL and testbench
===================================

CAM_FRAME_LOADER -- requirements
Module: cam_frame_loader

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; clock CLOCK_100, reset rst_n.
REQ-002 SHALL take parameters (name, default, meaning), one per line:
- BURST_LEN, 8, words per SDRAM write burst.
- FRAME_BURSTS, 9600, bursts per frame (FRAME_WORDS = BURST_LEN*FRAME_BURSTS).
- DEPTH, 16, FIFO entries (power of two, >= 2*BURST_LEN).
REQ-003 SHALL have these ports (name, direction, width, meaning), one per line:
- CLOCK_100  in  1  system clock, rising edge.
- rst_n  in  1  async active-low reset.
- CFL_rst_n  in  1  sync active-low soft reset from SDRAM controller.
- CFL_start  in  1  start capture of one frame.
- CFL_ack  in  1  controller accepted one burst (single-cycle pulse).
- CFL_ready  out  1  >= BURST_LEN words buffered, burst requested.
- CFL_finished  out  1  all FRAME_BURSTS bursts acknowledged.
- PIX_valid  in  1  pixel word valid.
- PIX_sof  in  1  qualifies PIX_valid: first word of frame.
- PIX_data  in  16  pixel word.
- FIFO_re  in  1  controller reads one word.
- FIFO_dout  out  16  read data, registered.
- FIFO_count  out  5  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: pixel dropped because FIFO full.

Function
REQ-004 SHALL implement states IDLE, WAIT_SOF, CAPTURE, DRAIN, DONE.
REQ-005 IDLE: CFL_start=1 -> WAIT_SOF; other inputs ignored.
REQ-006 WAIT_SOF: first cycle with PIX_valid=1 and PIX_sof=1 -> CAPTURE; that word is written as word 0; PIX_valid words without PIX_sof dropped, overflow not set.
REQ-007 CAPTURE: each PIX_valid word written when FIFO_count<DEPTH; word counter (17 bits) increments per written word; after word FRAME_WORDS-1 is written -> DRAIN.
REQ-008 Write at FIFO_count==DEPTH SHALL be dropped and SHALL set overflow, even if FIFO_re is high the same cycle; a dropped word does not advance the word counter.
REQ-009 PIX_sof during CAPTURE SHALL be ignored (treated as ordinary data).
REQ-010 DRAIN: PIX_valid ignored; waits for burst counter == FRAME_BURSTS -> DONE.
REQ-011 DONE: CFL_finished=1 (registered, asserted the cycle after the last CFL_ack); CFL_start=1 -> WAIT_SOF, clears CFL_finished, word and burst counters, overflow.
REQ-012 CFL_ready SHALL be registered: set in CAPTURE/DRAIN when FIFO_count >= BURST_LEN and CFL_ready=0; held until CFL_ack; cleared the cycle after CFL_ack; may re-assert no earlier than the second cycle after CFL_ack.
REQ-013 CFL_ack SHALL increment the 14-bit burst counter only while CFL_ready=1; CFL_ack with CFL_ready=0 ignored.
REQ-014 FIFO_re with FIFO_count>0: FIFO_dout updates with oldest word the next cycle, count decrements; FIFO_re at empty ignored, FIFO_dout holds.
REQ-015 Simultaneous accepted write and read: count unchanged; read of empty FIFO SHALL NOT return the word written that cycle.
REQ-016 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-017 CFL_rst_n=0 at a clock edge SHALL have priority over all else: state IDLE, FIFO flushed (count 0), counters 0, CFL_ready/CFL_finished/overflow 0; FIFO_dout holds.

Reset
REQ-018 rst_n=0 SHALL asynchronously force: state IDLE, FIFO_count 0, pointers 0, word/burst counters 0, CFL_ready 0, CFL_finished 0, overflow 0, FIFO_dout 16'h0000.
REQ-019 Deassertion of rst_n SHALL take effect on the first rising CLOCK_100 edge with rst_n=1; no capture before CFL_start.

Verification (bench: BURST_LEN=8, FRAME_BURSTS=4, DEPTH=16)
REQ-020 Start, SOF, 32 words 0x0000..0x001F, controller acks each burst and reads 8 words -> CFL_ready pulses 4 times, FIFO_dout sequence 0x0000..0x001F, CFL_finished=1 cycle after 4th ack, overflow=0.
REQ-021 20 words written, no FIFO_re -> FIFO_count=16, overflow=1, words 16..19 dropped, word counter=16.
REQ-022 PIX_valid with PIX_sof=0 (3 words) then SOF word 0xAAAA in WAIT_SOF -> first FIFO_dout after read = 0xAAAA.
REQ-023 FIFO_count=16, PIX_valid and FIFO_re same cycle -> count 15, overflow=1; FIFO_count=0 with both -> count 1, FIFO_dout unchanged.
REQ-024 CFL_rst_n=0 mid-CAPTURE with 10 words buffered and CFL_ready=1 -> next cycle IDLE, FIFO_count=0, CFL_ready=0; 40 words + SOF without CFL_start -> nothing written.
REQ-025 rst_n asserted asynchronously between edges in DRAIN -> all outputs at REQ-018 values immediately, before next edge.

Source files
------------

// File: rtl/cam_frame_loader.sv
// ----------------------------------------------------------------------------
// cam_frame_loader
//
// Buffers one camera frame of 16-bit pixel words in a small FIFO and hands it
// to an SDRAM controller in fixed-size write bursts.
//
//   IDLE     -> waits for CFL_start
//   WAIT_SOF -> discards pixel words until one arrives flagged with PIX_sof
//   CAPTURE  -> writes every valid pixel word until FRAME_WORDS are stored
//   DRAIN    -> ignores pixels, waits until every burst has been acknowledged
//   DONE     -> CFL_finished high until the next CFL_start
//
// Ports
//   CLOCK_100    system clock, rising edge
//   rst_n        asynchronous active-low reset
//   CFL_rst_n    synchronous active-low soft reset from the SDRAM controller
//   CFL_start    start capture of one frame
//   CFL_ack      controller accepted one burst (single-cycle pulse)
//   CFL_ready    registered burst request: >= BURST_LEN words buffered
//   CFL_finished registered: all FRAME_BURSTS bursts acknowledged
//   PIX_valid    pixel word valid
//   PIX_sof      first word of a frame (only meaningful in WAIT_SOF)
//   PIX_data     pixel word
//   FIFO_re      controller reads one word
//   FIFO_dout    registered read data
//   FIFO_count   FIFO occupancy, 0..DEPTH
//   overflow     sticky: a pixel was dropped because the FIFO was full
// ----------------------------------------------------------------------------
module cam_frame_loader #(
   parameter int BURST_LEN    = 8,
   parameter int FRAME_BURSTS = 9600,
   parameter int DEPTH        = 16
) (
   input  logic        CLOCK_100,
   input  logic        rst_n,
   input  logic        CFL_rst_n,
   input  logic        CFL_start,
   input  logic        CFL_ack,
   output logic        CFL_ready,
   output logic        CFL_finished,
   input  logic        PIX_valid,
   input  logic        PIX_sof,
   input  logic [15:0] PIX_data,
   input  logic        FIFO_re,
   output logic [15:0] FIFO_dout,
   output logic [4:0]  FIFO_count,
   output logic        overflow
);

   localparam int AW          = $clog2(DEPTH);
   localparam int FRAME_WORDS = BURST_LEN * FRAME_BURSTS;

   typedef enum logic [2:0] {IDLE, WAIT_SOF, CAPTURE, DRAIN, DONE} state_t;

   state_t         state_reg;
   logic [AW-1:0]  wr_ptr_reg;
   logic [AW-1:0]  rd_ptr_reg;
   logic [4:0]     count_reg;
   logic [16:0]    word_cnt_reg;
   logic [13:0]    burst_cnt_reg;
   logic           ready_reg;
   logic           finished_reg;
   logic           overflow_reg;
   logic [15:0]    dout_reg;

   logic [15:0]    mem [DEPTH];

   logic           wr_req;
   logic           fifo_full;
   logic           wr_acc;
   logic           wr_drop;
   logic           rd_acc;
   logic           burst_hit;
   logic [13:0]    burst_next;

   // Only the SOF word is eligible in WAIT_SOF; in CAPTURE PIX_sof is plain data.
   assign wr_req     = (state_reg == WAIT_SOF && PIX_valid && PIX_sof) ||
                       (state_reg == CAPTURE  && PIX_valid);
   // Fullness uses the registered count, so a same-cycle read never makes room.
   assign fifo_full  = (count_reg == 5'(DEPTH));
   assign wr_acc     = wr_req && !fifo_full;
   assign wr_drop    = wr_req &&  fifo_full;
   // Reads only come from stored words, never from the word written this cycle.
   assign rd_acc     = FIFO_re && (count_reg != 5'd0);
   assign burst_hit  = CFL_ack && ready_reg;
   assign burst_next = burst_cnt_reg + 14'(burst_hit);

   // Storage array has no reset so it can map onto RAM primitives.
   always_ff @(posedge CLOCK_100) begin
      if (wr_acc && CFL_rst_n)
         mem[wr_ptr_reg] <= PIX_data;
   end

   always_ff @(posedge CLOCK_100 or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         word_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
         ready_reg     <= 1'b0;
         finished_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
         dout_reg      <= 16'h0000;
      end else if (!CFL_rst_n) begin
         // Soft reset flushes everything except the last read data.
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         word_cnt_reg  <= '0;
         burst_cnt_reg <= '0;
         ready_reg     <= 1'b0;
         finished_reg  <= 1'b0;
         overflow_reg  <= 1'b0;
      end else begin
         if (wr_acc)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_acc) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
            dout_reg   <= mem[rd_ptr_reg];
         end
         case ({wr_acc, rd_acc})
            2'b10:   count_reg <= count_reg + 5'd1;
            2'b01:   count_reg <= count_reg - 5'd1;
            default: count_reg <= count_reg;
         endcase

         if (wr_drop)
            overflow_reg <= 1'b1;
         if (burst_hit)
            burst_cnt_reg <= burst_next;

         // Request is held until acknowledged; after the ack it drops for one
         // cycle before it can be re-evaluated from the then-current count.
         if (ready_reg) begin
            if (CFL_ack)
               ready_reg <= 1'b0;
         end else if ((state_reg == CAPTURE || state_reg == DRAIN) &&
                      count_reg >= 5'(BURST_LEN) &&
                      burst_cnt_reg < 14'(FRAME_BURSTS)) begin
            ready_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (CFL_start) begin
                  state_reg     <= WAIT_SOF;
                  word_cnt_reg  <= '0;
                  burst_cnt_reg <= '0;
                  overflow_reg  <= 1'b0;
                  finished_reg  <= 1'b0;
               end
            end
            WAIT_SOF: begin
               if (wr_acc) begin
                  word_cnt_reg <= 17'd1;
                  state_reg    <= (FRAME_WORDS == 1) ? DRAIN : CAPTURE;
               end
            end
            CAPTURE: begin
               if (wr_acc) begin
                  word_cnt_reg <= word_cnt_reg + 17'd1;
                  if (word_cnt_reg == 17'(FRAME_WORDS - 1))
                     state_reg <= DRAIN;
               end
            end
            DRAIN: begin
               // Look at the post-ack count so finished rises right after the last ack.
               if (burst_next == 14'(FRAME_BURSTS)) begin
                  state_reg    <= DONE;
                  finished_reg <= 1'b1;
               end
            end
            DONE: begin
               if (CFL_start) begin
                  state_reg     <= WAIT_SOF;
                  finished_reg  <= 1'b0;
                  word_cnt_reg  <= '0;
                  burst_cnt_reg <= '0;
                  overflow_reg  <= 1'b0;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign CFL_ready    = ready_reg;
   assign CFL_finished = finished_reg;
   assign FIFO_dout    = dout_reg;
   assign FIFO_count   = count_reg;
   assign overflow     = overflow_reg;

endmodule

// File: tb/tb_cam_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_cam_frame_loader
//
// Directed bench for cam_frame_loader with BURST_LEN=8, FRAME_BURSTS=4,
// DEPTH=16 (32-word frames). Inputs change 1 ns after the rising edge and
// outputs are sampled at the same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_cam_frame_loader;

   logic        clk;
   logic        rst_n;
   logic        CFL_rst_n;
   logic        CFL_start;
   logic        CFL_ack;
   logic        CFL_ready;
   logic        CFL_finished;
   logic        PIX_valid;
   logic        PIX_sof;
   logic [15:0] PIX_data;
   logic        FIFO_re;
   logic [15:0] FIFO_dout;
   logic [4:0]  FIFO_count;
   logic        overflow;

   int pass_cnt  = 0;
   int check_cnt = 0;

   cam_frame_loader #(
      .BURST_LEN   (8),
      .FRAME_BURSTS(4),
      .DEPTH       (16)
   ) dut (
      .CLOCK_100   (clk),
      .rst_n       (rst_n),
      .CFL_rst_n   (CFL_rst_n),
      .CFL_start   (CFL_start),
      .CFL_ack     (CFL_ack),
      .CFL_ready   (CFL_ready),
      .CFL_finished(CFL_finished),
      .PIX_valid   (PIX_valid),
      .PIX_sof     (PIX_sof),
      .PIX_data    (PIX_data),
      .FIFO_re     (FIFO_re),
      .FIFO_dout   (FIFO_dout),
      .FIFO_count  (FIFO_count),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
         $display("check %-18s observed %0h expected %0h ok", tag, obs, exp);
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One 32-word frame as four write-8 / read-8 / ack rounds.
   task automatic run_frame(input logic [15:0] base, input bit last_ack);
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 8; i++) begin
            PIX_valid = 1'b1;
            PIX_sof   = (b == 0 && i == 0);
            PIX_data  = base + 16'(b * 8 + i);
            tick();
         end
         PIX_valid = 1'b0;
         PIX_sof   = 1'b0;
         check("count_after_burst", 32'(FIFO_count), 32'd8);
         check("ready_not_yet", 32'(CFL_ready), 32'd0);
         tick();
         check("ready_set", 32'(CFL_ready), 32'd1);
         for (int i = 0; i < 8; i++) begin
            FIFO_re = 1'b1;
            tick();
            check("dout_seq", 32'(FIFO_dout), 32'(base + 16'(b * 8 + i)));
            check("ready_held", 32'(CFL_ready), 32'd1);
         end
         FIFO_re = 1'b0;
         check("count_drained", 32'(FIFO_count), 32'd0);
         check("finished_early", 32'(CFL_finished), 32'd0);
         if (b < 3 || last_ack) begin
            CFL_ack = 1'b1;
            tick();
            CFL_ack = 1'b0;
            check("ready_clr_on_ack", 32'(CFL_ready), 32'd0);
            check("finished_after_ack", 32'(CFL_finished), (b == 3) ? 32'd1 : 32'd0);
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      CFL_rst_n = 1'b1;
      CFL_start = 1'b0;
      CFL_ack   = 1'b0;
      PIX_valid = 1'b0;
      PIX_sof   = 1'b0;
      PIX_data  = 16'h0000;
      FIFO_re   = 1'b0;
      tick();
      tick();

      // Reset state
      check("rst_count", 32'(FIFO_count), 32'd0);
      check("rst_ready", 32'(CFL_ready), 32'd0);
      check("rst_finished", 32'(CFL_finished), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_dout", 32'(FIFO_dout), 32'h0000);
      rst_n = 1'b1;
      tick();

      // Nothing is captured before CFL_start
      PIX_valid = 1'b1; PIX_sof = 1'b1; PIX_data = 16'h5555;
      tick();
      PIX_valid = 1'b0; PIX_sof = 1'b0;
      check("idle_no_capture", 32'(FIFO_count), 32'd0);

      // Full frame 0x0000..0x001F; stray ack with ready low is ignored
      CFL_start = 1'b1;
      tick();
      CFL_start = 1'b0;
      CFL_ack   = 1'b1;
      tick();
      CFL_ack   = 1'b0;
      run_frame(16'h0000, 1'b1);
      check("frame_overflow", 32'(overflow), 32'd0);

      // Restart from DONE; non-SOF words are dropped silently
      CFL_start = 1'b1;
      tick();
      CFL_start = 1'b0;
      check("restart_finished", 32'(CFL_finished), 32'd0);
      for (int i = 0; i < 3; i++) begin
         PIX_valid = 1'b1; PIX_sof = 1'b0; PIX_data = 16'h1111 + 16'(i);
         tick();
      end
      check("nosof_dropped", 32'(FIFO_count), 32'd0);
      check("nosof_no_ovf", 32'(overflow), 32'd0);

      // SOF word 0xAAAA plus 19 more: 4 words dropped at full
      PIX_sof = 1'b1; PIX_data = 16'hAAAA;
      tick();
      PIX_sof = 1'b0;
      for (int i = 1; i < 20; i++) begin
         PIX_data = 16'h0100 + 16'(i);
         tick();
      end
      PIX_valid = 1'b0;
      check("full_count", 32'(FIFO_count), 32'd16);
      check("full_overflow", 32'(overflow), 32'd1);
      check("full_word_cnt", 32'(dut.word_cnt_reg), 32'd16);

      // Write and read together at full: write still dropped
      PIX_valid = 1'b1; PIX_data = 16'hBEEF; FIFO_re = 1'b1;
      tick();
      PIX_valid = 1'b0; FIFO_re = 1'b0;
      check("full_rw_count", 32'(FIFO_count), 32'd15);
      check("full_rw_ovf", 32'(overflow), 32'd1);
      check("sof_first_dout", 32'(FIFO_dout), 32'hAAAA);
      check("full_rw_word_cnt", 32'(dut.word_cnt_reg), 32'd16);

      for (int i = 1; i < 16; i++) begin
         FIFO_re = 1'b1;
         tick();
         check("dout_after_full", 32'(FIFO_dout), 32'(16'h0100 + 16'(i)));
      end
      FIFO_re = 1'b0;
      check("empty_count", 32'(FIFO_count), 32'd0);

      // Write and read together at empty: read ignored
      PIX_valid = 1'b1; PIX_data = 16'h0200; FIFO_re = 1'b1;
      tick();
      PIX_valid = 1'b0; FIFO_re = 1'b0;
      check("empty_rw_count", 32'(FIFO_count), 32'd1);
      check("empty_rw_dout", 32'(FIFO_dout), 32'h010F);

      // Buffer 10 words with the request outstanding, then soft reset
      for (int i = 1; i < 10; i++) begin
         PIX_valid = 1'b1; PIX_data = 16'h0200 + 16'(i);
         tick();
      end
      PIX_valid = 1'b0;
      check("pre_soft_count", 32'(FIFO_count), 32'd10);
      check("pre_soft_ready", 32'(CFL_ready), 32'd1);
      CFL_rst_n = 1'b0;
      tick();
      CFL_rst_n = 1'b1;
      check("soft_count", 32'(FIFO_count), 32'd0);
      check("soft_ready", 32'(CFL_ready), 32'd0);
      check("soft_overflow", 32'(overflow), 32'd0);
      check("soft_dout_hold", 32'(FIFO_dout), 32'h010F);
      for (int i = 0; i < 40; i++) begin
         PIX_valid = 1'b1; PIX_sof = (i == 0); PIX_data = 16'h0400 + 16'(i);
         tick();
      end
      PIX_valid = 1'b0; PIX_sof = 1'b0;
      check("soft_idle_count", 32'(FIFO_count), 32'd0);
      check("soft_idle_ready", 32'(CFL_ready), 32'd0);

      // Frame left in DRAIN with a request pending, then async reset mid-cycle
      CFL_start = 1'b1;
      tick();
      CFL_start = 1'b0;
      run_frame(16'h0300, 1'b0);
      check("drain_ready", 32'(CFL_ready), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_count", 32'(FIFO_count), 32'd0);
      check("async_ready", 32'(CFL_ready), 32'd0);
      check("async_finished", 32'(CFL_finished), 32'd0);
      check("async_overflow", 32'(overflow), 32'd0);
      check("async_dout", 32'(FIFO_dout), 32'h0000);
      tick();
      rst_n = 1'b1;
      tick();
      PIX_valid = 1'b1; PIX_sof = 1'b1; PIX_data = 16'h7777;
      tick();
      PIX_valid = 1'b0; PIX_sof = 1'b0;
      check("post_async_idle", 32'(FIFO_count), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
